// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB memory responder.
// Imported by the responder RTL.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int APB_ADDR_W   = 16;
  localparam int APB_DATA_W   = 32;
  localparam int APB_MAX_WAIT = 15;

endpackage

// File: rtl/apb_mem_responder.sv
// APB completer backed by a word-indexed memory, with
// programmable wait states and an out-of-range error response.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic              PWrite,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] memory [DEPTH];

  apb_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_cnt;

  logic              w_setup;
  logic              w_new_err;
  logic              w_cur_err;
  logic              w_done;
  logic [DATA_W-1:0] w_new_rd;
  logic [DATA_W-1:0] w_cur_rd;

  assign w_setup   = PSel & ~PEnable;
  assign w_new_err = {1'b0, PAddr} >= LP_DEPTH;
  assign w_cur_err = {1'b0, r_addr} >= LP_DEPTH;
  assign w_new_rd  = w_new_err ? '0
                   : memory[PAddr[IDX_W-1:0]];
  assign w_cur_rd  = w_cur_err ? '0
                   : memory[r_addr[IDX_W-1:0]];
  assign w_done    = (r_state == ACCESS) & PSel
                   & PEnable & PReady;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      PReady  <= 1'b0;
      PSlvErr <= 1'b0;
      PRData  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          PReady  <= 1'b0;
          PSlvErr <= 1'b0;
          if (w_setup) begin
            r_addr  <= PAddr;
            r_write <= PWrite;
            r_wdata <= PWData;
            r_cnt   <= LP_WAIT;
            r_state <= ACCESS;
            // zero wait states: response is ready in access cycle 1
            if (LP_WAIT == 4'd0) begin
              PReady  <= 1'b1;
              PSlvErr <= w_new_err;
              if (!PWrite) PRData <= w_new_rd;
            end
          end
        end
        ACCESS: begin
          if (!PSel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            PReady  <= 1'b0;
            PSlvErr <= 1'b0;
          end else if (PReady) begin
            if (PEnable) begin
              r_state <= IDLE;
              PReady  <= 1'b0;
              PSlvErr <= 1'b0;
            end
          end else begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
              PReady  <= 1'b1;
              PSlvErr <= w_cur_err;
              if (!r_write) PRData <= w_cur_rd;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // storage survives reset; reset only stops an open transfer
  always_ff @(posedge clk) begin
    if (w_done && r_write && !w_cur_err)
      memory[r_addr[IDX_W-1:0]] <= r_wdata;
  end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Bench for apb_mem_responder: three instances with different
// wait-state counts, a vector table, corner sequences, random traffic.
module tb_apb_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        psel   [3];
  logic        pen    [3];
  logic        pwr    [3];
  logic [15:0] paddr  [3];
  logic [31:0] pwdata [3];
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr[3];

  int ws[3] = '{0, 3, 2};

  apb_mem_responder #(.WAIT_STATES(0)) mem (
    .clk(clk), .Rst(rst), .PSel(psel[0]), .PEnable(pen[0]),
    .PWrite(pwr[0]), .PAddr(paddr[0]), .PWData(pwdata[0]),
    .PRData(prdata[0]), .PReady(pready[0]), .PSlvErr(pslverr[0])
  );

  apb_mem_responder #(.WAIT_STATES(3)) mem3 (
    .clk(clk), .Rst(rst), .PSel(psel[1]), .PEnable(pen[1]),
    .PWrite(pwr[1]), .PAddr(paddr[1]), .PWData(pwdata[1]),
    .PRData(prdata[1]), .PReady(pready[1]), .PSlvErr(pslverr[1])
  );

  apb_mem_responder #(.WAIT_STATES(2)) mem2 (
    .clk(clk), .Rst(rst), .PSel(psel[2]), .PEnable(pen[2]),
    .PWrite(pwr[2]), .PAddr(paddr[2]), .PWData(pwdata[2]),
    .PRData(prdata[2]), .PReady(pready[2]), .PSlvErr(pslverr[2])
  );

  typedef struct {
    int          k;
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } vec_t;

  vec_t vt[$];

  int errs = 0;
  int checks = 0;

  logic [31:0] ref_mem [3][256];
  bit          ref_vld [3][256];
  logic [31:0] last_rd [3];
  bit          last_ok [3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_wr(int k, logic [15:0] a,
                                   logic [31:0] d);
    if (a < 16'd256) begin
      ref_mem[k][a[7:0]] = d;
      ref_vld[k][a[7:0]] = 1'b1;
    end
  endfunction

  function automatic void rst_model();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = '0;
      last_ok[k] = 1'b1;
    end
  endfunction

  task automatic idle_all();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0;
      pen[k]  = 1'b0;
    end
  endtask

  task automatic xfer(input int k, input bit wr,
                      input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err,
                      output int acyc);
    @(negedge clk);
    chk("idle_rdy", {31'b0, pready[k]}, 32'd0);
    psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr;
    paddr[k] = a; pwdata[k] = d;
    @(negedge clk);
    pen[k] = 1'b1;
    paddr[k] = 16'($urandom);
    pwdata[k] = $urandom;
    acyc = 1;
    while (pready[k] !== 1'b1 && acyc < 40) begin
      @(negedge clk);
      acyc++;
    end
    rd = prdata[k];
    err = pslverr[k];
  endtask

  task automatic mxfer(input int k, input bit wr,
                       input logic [15:0] a, input logic [31:0] d,
                       input string tag);
    logic [31:0] rd;
    logic        err;
    int          acyc;
    bit          eerr;
    eerr = (a >= 16'd256);
    xfer(k, wr, a, d, rd, err, acyc);
    chk({tag, "_cyc"}, acyc, ws[k] + 1);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, eerr});
    if (!wr) begin
      if (eerr) begin
        chk({tag, "_rd"}, rd, 32'd0);
        last_rd[k] = '0;
        last_ok[k] = 1'b1;
      end else if (ref_vld[k][a[7:0]]) begin
        chk({tag, "_rd"}, rd, ref_mem[k][a[7:0]]);
        last_rd[k] = ref_mem[k][a[7:0]];
        last_ok[k] = 1'b1;
      end else begin
        last_ok[k] = 1'b0;
      end
    end else begin
      if (!eerr && last_ok[k])
        chk({tag, "_hold"}, rd, last_rd[k]);
      if (!eerr) model_wr(k, a, d);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acyc;
    bit          seen;

    vt.push_back('{0, 1, 16'h0050, 32'h50, 32'h0, 1'b0, 1});
    vt.push_back('{0, 0, 16'h0050, 32'h0, 32'h50, 1'b0, 1});
    vt.push_back('{1, 1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 4});
    vt.push_back('{1, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 4});
    vt.push_back('{0, 1, 16'h0000, 32'hA5A5A5A5, 32'h0, 1'b0, 1});
    vt.push_back('{0, 1, 16'h0100, 32'h12345678, 32'h0, 1'b1, 1});
    vt.push_back('{0, 0, 16'h0100, 32'h0, 32'h0, 1'b1, 1});
    vt.push_back('{0, 0, 16'h0000, 32'h0, 32'hA5A5A5A5, 1'b0, 1});
    vt.push_back('{2, 1, 16'h00FF, 32'h11, 32'h0, 1'b0, 3});
    vt.push_back('{2, 0, 16'h00FF, 32'h0, 32'h11, 1'b0, 3});
    vt.push_back('{2, 1, 16'hFFFF, 32'h77, 32'h0, 1'b1, 3});

    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0;
      paddr[k] = '0; pwdata[k] = '0;
      for (int j = 0; j < 256; j++) ref_vld[k][j] = 1'b0;
    end
    rst_model();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdy", {31'b0, pready[k]}, 32'd0);
      chk("rst_err", {31'b0, pslverr[k]}, 32'd0);
      chk("rst_rd", prdata[k], 32'd0);
    end
    rst = 1'b0;

    foreach (vt[i]) begin
      xfer(vt[i].k, vt[i].wr, vt[i].a, vt[i].d, rd, err, acyc);
      chk("vec_cyc", acyc, vt[i].cyc);
      chk("vec_err", {31'b0, err}, {31'b0, vt[i].err});
      if (!vt[i].wr) begin
        chk("vec_rd", rd, vt[i].rd);
        last_rd[vt[i].k] = vt[i].rd;
      end else if (!vt[i].err) begin
        model_wr(vt[i].k, vt[i].a, vt[i].d);
      end
    end
    chk("mem_50", mem.memory[8'h50], 32'h50);
    chk("mem_00", mem.memory[8'h00], 32'hA5A5A5A5);
    idle_all();

    // abort in the access phase must leave memory untouched
    mxfer(2, 1'b1, 16'h0020, 32'hCAFEF00D, "ab_pre");
    idle_all();
    seen = 1'b0;
    @(negedge clk);
    psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1;
    paddr[2] = 16'h0020; pwdata[2] = 32'h00000BAD;
    @(negedge clk);
    pen[2] = 1'b1;
    seen |= pready[2];
    @(negedge clk);
    seen |= pready[2];
    psel[2] = 1'b0; pen[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= pready[2];
    end
    chk("abort_rdy", {31'b0, seen}, 32'd0);
    mxfer(2, 1'b0, 16'h0020, 32'h0, "ab_post");
    idle_all();

    // PEnable without a setup phase is ignored
    seen = 1'b0;
    @(negedge clk);
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1;
    paddr[0] = 16'h0050; pwdata[0] = 32'h99;
    repeat (4) begin
      @(negedge clk);
      seen |= pready[0];
    end
    chk("noset_rdy", {31'b0, seen}, 32'd0);
    idle_all();
    mxfer(0, 1'b0, 16'h0050, 32'h0, "noset_rd");
    idle_all();

    // reset in the middle of a wait-state write
    @(negedge clk);
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1;
    paddr[1] = 16'h0010; pwdata[1] = 32'h0BADF00D;
    @(negedge clk);
    pen[1] = 1'b1;
    @(negedge clk);
    chk("pre_rst_rd", prdata[1], 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", {31'b0, pready[1]}, 32'd0);
    chk("mid_rst_rd", prdata[1], 32'd0);
    chk("mid_rst_err", {31'b0, pslverr[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    psel[1] = 1'b0; pen[1] = 1'b0;
    rst_model();
    mxfer(1, 1'b0, 16'h0010, 32'h0, "post_rst");
    mxfer(1, 1'b1, 16'h0011, 32'h13572468, "post_rst_w");
    mxfer(1, 1'b0, 16'h0011, 32'h0, "post_rst_r");
    idle_all();

    for (int i = 0; i < 200; i++) begin
      int          k;
      bit          wr;
      logic [15:0] a;
      k  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 16'(256 + $urandom_range(0, 65279));
      else
        a = 16'($urandom_range(0, 15));
      mxfer(k, wr, a, $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) idle_all();
    end
    idle_all();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_responder.md
Name: apb_mem_responder

Overview:
- APB completer (slave) end of the peripheral bus driven by the team's test initiators: decodes PSel/PEnable/PWrite/PAddr/PWData, stores write data in a word-indexed memory and returns read data.
- Provides programmable wait states (PReady) and error response (PSlvErr) so initiator benches can exercise both.
- Instantiated as `mem` under `top`. The storage array is named `memory` and is indexed directly by PAddr, with no byte shift. A write of 32'h50 to PAddr 16'h50 must therefore appear at top.mem.memory[16'h50].

Parameters:
- ADDR_W, 16, PAddr width.
- DATA_W, 32, PWData/PRData width.
- DEPTH, 256, number of memory words; valid addresses are 0..DEPTH-1.
- WAIT_STATES, 0, number of access-phase cycles with PReady low before completion (0..15).

Ports:
- clk  in  1  bus clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- PSel  in  1  select from initiator.
- PEnable  in  1  access-phase strobe.
- PWrite  in  1  1 = write, 0 = read.
- PAddr  in  ADDR_W  word address.
- PWData  in  DATA_W  write data.
- PRData  out  DATA_W  read data; valid while PReady is high on a read.
- PReady  out  1  transfer-complete indication.
- PSlvErr  out  1  error indication; valid only while PReady is high.

Behaviour:
- Reset (Rst=1, asynchronous):
  - State = IDLE; PReady=0, PSlvErr=0, PRData=0; wait counter=0.
  - memory is not cleared; its contents are retained across reset and are undefined at power-up.
- All outputs are registered. There are two states: IDLE and ACCESS.
- IDLE:
  - Setup detect is PSel=1 and PEnable=0.
  - On setup detect, capture PAddr, PWrite and PWData; load cnt=WAIT_STATES; go to ACCESS.
  - If WAIT_STATES=0, drive PReady=1 for the next cycle.
  - PEnable=1 seen in IDLE with no preceding setup is a protocol violation: ignore it, stay in IDLE, keep PReady=0.
- ACCESS:
  - If PSel=0, abort: go to IDLE, no write, PReady=0.
  - Otherwise, while cnt>0: decrement cnt and keep PReady=0. When cnt reaches 0, drive PReady=1 in the following cycle.
  - PReady is therefore high during access-phase cycle WAIT_STATES+1, counting from 1.
- Completion occurs on the edge where PSel=1, PEnable=1 and PReady=1:
  - Write with captured address < DEPTH: memory[addr] <= captured PWData.
  - Read: PRData is loaded with memory[addr] in the same cycle that PReady rises, so it is valid alongside PReady.
  - Captured address >= DEPTH: PSlvErr=1 together with PReady; the write is suppressed; PRData=0.
  - After completion, go to IDLE. PReady and PSlvErr return to 0 on the next cycle. PRData holds its value until the next read completes.
- Back-to-back transfers:
  - A new setup may arrive in the cycle immediately after completion; it is accepted from IDLE.
  - Throughput is one transfer per WAIT_STATES+2 cycles.
- Address/data changes during ACCESS are ignored; only the values captured in setup are used.
- Read-after-write to the same address returns the new data: the write has committed before the next setup.
- Reset asserted mid-transfer:
  - The transfer is dropped and no write occurs unless the completing edge has already passed.
  - Outputs go to their reset values immediately.

Decomposition:
- Package apb_pkg:
  - typedef enum {IDLE, ACCESS} apb_state_e;
  - default width constants APB_ADDR_W=16 and APB_DATA_W=32;
  - constant APB_MAX_WAIT=15.
- Single module; no sub-module needed. The wait counter is 4 bits inline.

Test Plan:
- Rst pulse, then write PAddr=16'h50, PWData=32'h50, WAIT_STATES=0 -> PReady high in the first access cycle; memory[16'h50]==32'h50; PSlvErr=0.
- Read PAddr=16'h50 after that write -> PRData=32'h50 with PReady=1 in the first access cycle.
- WAIT_STATES=3, write 16'h10=32'hDEADBEEF then read it back -> PReady low for 3 access cycles and high on the 4th; read returns 32'hDEADBEEF.
- Write PAddr=16'h0100 with DEPTH=256 -> PSlvErr=1 with PReady; no memory change. Read of the same address -> PRData=0, PSlvErr=1.
- Abort: setup write to 16'h20, drop PSel in the access phase with WAIT_STATES=2 -> memory[16'h20] unchanged; PReady never asserts. PEnable=1 without setup -> no PReady.
- Rst asserted during a wait-state write -> PReady=0 and PRData=0 immediately; memory[addr] unchanged. The next transfer completes normally.
